// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave that maps IM/input/weight buffer writes, output-buffer
// reads and a small control/status block onto a single SRAM-controller port.
module wb_slave_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [1:0]  select_buff,
   output logic        buffer_wr_en,
   output logic        buffer_rd_en,
   output logic [5:0]  buffer_addr,
   output logic [31:0] buffer_data_o,
   input  logic [31:0] buffer_data_i,
   input  logic [7:0]  buf_flags,
   output logic        enable_PC_IM,
   output logic        cntrl_reset
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, ACK} state_t;

   state_t      state_reg, state_next;
   logic [11:0] adr_reg;
   logic [1:0]  ctrl_dat_reg;
   logic        we_reg;
   logic [3:0]  sel_reg;

   logic        base_match, accept;
   logic [4:0]  region_hot;
   logic        in_range, wr_ok, ctrl_off0, ctrl_off4;
   logic        ack_next, wr_next, rd_next;
   logic [31:0] rdata_next;

   assign base_match = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign accept     = (state_reg == IDLE) && wbs_cyc_i && wbs_stb_i && base_match && !wbs_ack_o;

   // One-hot decode of the mapped regions (0..4); anything else is unmapped.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_region
         assign region_hot[gi] = (adr_reg[11:8] == 4'(gi));
      end
   endgenerate

   assign in_range  = region_hot[0] || (adr_reg[7:6] == 2'b00);
   assign wr_ok     = (region_hot[0] || region_hot[1] || region_hot[2]) && in_range && (|sel_reg);
   assign ctrl_off0 = region_hot[4] && (adr_reg[7:0] == 8'h00);
   assign ctrl_off4 = region_hot[4] && (adr_reg[7:0] == 8'h04);

   always_comb begin
      state_next = state_reg;
      ack_next   = 1'b0;
      wr_next    = 1'b0;
      rd_next    = 1'b0;
      rdata_next = 32'h0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (wbs_we_i)                    state_next = WRITE;
               else if (wbs_adr_i[11:8] == 4'd3) state_next = RD_REQ;
               else                             state_next = ACK;
            end
         end
         WRITE: begin
            wr_next    = wr_ok;
            ack_next   = 1'b1;
            state_next = IDLE;
         end
         RD_REQ: begin
            rd_next    = 1'b1;
            state_next = RD_WAIT;
         end
         RD_WAIT: state_next = ACK;
         ACK: begin
            ack_next   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Strobes are registered, so buffer_data_i answers during ACK.
      if (region_hot[3])  rdata_next = buffer_data_i;
      else if (ctrl_off0) rdata_next = {30'b0, cntrl_reset, enable_PC_IM};
      else if (ctrl_off4) rdata_next = {24'b0, buf_flags};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         adr_reg       <= '0;
         ctrl_dat_reg  <= '0;
         we_reg        <= 1'b0;
         sel_reg       <= '0;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         buffer_wr_en  <= 1'b0;
         buffer_rd_en  <= 1'b0;
         select_buff   <= '0;
         buffer_addr   <= '0;
         buffer_data_o <= '0;
         enable_PC_IM  <= 1'b0;
         cntrl_reset   <= 1'b1;
      end else begin
         state_reg    <= state_next;
         wbs_ack_o    <= ack_next;
         buffer_wr_en <= wr_next;
         buffer_rd_en <= rd_next;
         // Buffer-side address/data settle a cycle ahead of the strobe.
         if (accept) begin
            adr_reg       <= wbs_adr_i[11:0];
            ctrl_dat_reg  <= wbs_dat_i[1:0];
            we_reg        <= wbs_we_i;
            sel_reg       <= wbs_sel_i;
            select_buff   <= wbs_adr_i[9:8];
            buffer_addr   <= (wbs_adr_i[11:8] == 4'd0) ? wbs_adr_i[7:2] : {2'b00, wbs_adr_i[5:2]};
            buffer_data_o <= wbs_dat_i;
         end
         if (state_reg == ACK && !we_reg)
            wbs_dat_o <= rdata_next;
         if (state_reg == WRITE && ctrl_off0 && sel_reg[0]) begin
            enable_PC_IM <= ctrl_dat_reg[0];
            cntrl_reset  <= ctrl_dat_reg[1];
         end
      end
   end

endmodule

// File: doc/wb_slave_bridge.md
WB_SLAVE_BRIDGE -- requirements
Module: wb_slave_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset (Wishbone wb_rst_i).
REQ-003 SHALL have ports: wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic-cycle controls.
REQ-004 SHALL have ports: wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-005 SHALL have ports: wbs_ack_o  out  1  registered acknowledge; wbs_dat_o  out  32  registered read data.
REQ-006 SHALL have ports: select_buff  out  2  target buffer (0 IM, 1 input, 2 weight); buffer_wr_en  out  1  write strobe.
REQ-007 SHALL have ports: buffer_rd_en  out  1  output-buffer read strobe; buffer_addr  out  6  word index; buffer_data_o  out  32  write data.
REQ-008 SHALL have ports: buffer_data_i  in  32  output-buffer read data, valid 1 cycle after buffer_rd_en.
REQ-009 SHALL have ports: buf_flags  in  8  {Output_full, Output_empty, Weight_full, Weight_empty, IN_full, IN_empty, IM_full, IM_empty} (MSB..LSB).
REQ-010 SHALL have ports: enable_PC_IM  out  1  program-counter enable; cntrl_reset  out  1  SRAM-controller reset.
REQ-011 SHALL have parameter BASE_ADDR, default 32'h3000_0000, decode base; match on wbs_adr_i[31:12]==BASE_ADDR[31:12].

Function
REQ-012 Region = wbs_adr_i[11:8]: 0 IM (index adr[7:2], 64 words), 1 input buffer, 2 weight buffer, 3 output buffer (read-only), 4 control/status; 5-15 unmapped.
REQ-013 Regions 1-3: valid index adr[5:2] (16 words); adr[7:6]!=0 is out-of-range.
REQ-014 FSM states IDLE, WRITE, RD_REQ, RD_WAIT, ACK; reset state IDLE.
REQ-015 IDLE: on cyc&stb&base-match&!wbs_ack_o, latch adr, dat, we, sel; next state WRITE if we, else RD_REQ for region 3, else ACK.
REQ-016 Request with cyc&stb and no base match SHALL be ignored (no ack, no strobes).
REQ-017 select_buff, buffer_addr, buffer_data_o SHALL be driven from latched values one cycle before, and held throughout, any strobe.
REQ-018 WRITE, regions 0-2, in-range, sel!=0: buffer_wr_en=1 exactly one cycle; wbs_ack_o=1 same cycle; next IDLE.
REQ-019 WRITE, region 3, out-of-range, unmapped, or sel==0: no strobe, ack same cycle, write discarded.
REQ-020 WRITE, region 4 offset 0x00: enable_PC_IM<=dat[0], cntrl_reset<=dat[1] when sel[0]=1; ack same cycle.
REQ-021 RD_REQ: buffer_rd_en=1 one cycle, buffer_addr=latched adr[5:2]; next RD_WAIT.
REQ-022 RD_WAIT: capture buffer_data_i into wbs_dat_o; next ACK.
REQ-023 ACK: wbs_ack_o=1 one cycle; next IDLE.
REQ-024 Read data: region 3 -> captured buffer data; region 4 offset 0x00 -> {30'b0, cntrl_reset, enable_PC_IM}; offset 0x04 -> {24'b0, buf_flags}; all else (regions 0-2, unmapped) -> 32'h0.
REQ-025 Latency: write ack 2 cycles after request accepted edge; region-3 read ack 4 cycles; other reads 2 cycles.
REQ-026 wbs_ack_o SHALL be high for exactly one cycle per accepted request; back-to-back request accepted no earlier than the cycle after ack.
REQ-027 buffer_wr_en and buffer_rd_en SHALL never be simultaneously high.
REQ-028 cyc or stb dropped mid-transaction: FSM completes sequence (strobe included), ack still pulsed, then IDLE.
REQ-029 wbs_dat_o SHALL hold last value except when updated per REQ-022/REQ-024.

Reset
REQ-030 reset=1 at clk edge: state IDLE; wbs_ack_o, buffer_wr_en, buffer_rd_en, enable_PC_IM = 0; cntrl_reset = 1; wbs_dat_o, buffer_data_o = 0; buffer_addr = 0; select_buff = 0.
REQ-031 reset asserted mid-transaction SHALL abort it with no ack and no further strobes.

Verification
REQ-032 Write 0x3000_0014 data 0x1234_5678 sel F -> select_buff=0, buffer_addr=5, buffer_data_o=0x12345678, one-cycle buffer_wr_en, ack same cycle.
REQ-033 Read 0x3000_0308 with buffer_data_i=0xCAFE_0001 -> buffer_rd_en with addr 2, ack 4 cycles later, wbs_dat_o=0xCAFE0001.
REQ-034 Write 0x3000_0400 data 0x1 then read 0x3000_0404 with buf_flags=0xA5 -> enable_PC_IM=1, cntrl_reset=0, read data 0x0000_00A5.
REQ-035 Write to 0x3000_0300, 0x3000_0140 and 0x3000_0900 -> each acked, no buffer_wr_en.
REQ-036 Assert reset during RD_WAIT -> no ack, outputs per REQ-030 next cycle; following write completes normally.
REQ-037 Request at 0x2000_0000 -> no ack and no strobes for 10 cycles.
